// File: rtl/step_pkg.sv
// Shared types and constants for the seven-segment scroller.
// Active-low display encodings: a blank digit drives all ones.
package step_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHOW,
        GAP
    } state_t;

    localparam logic [3:0] SSEG_BLANK_NUM_N = 4'hF;
    localparam logic       SSEG_OFF_N       = 1'b1;

endpackage

// File: rtl/dwell_timer.sv
// Saturating cycle counter: last is high while the count sits at LIMIT-1.
// Latency: clr takes effect at the next edge. No handshake; en only gates counting.
// pre flags LIMIT-2 so a caller can register an event that lines up with last.
module dwell_timer #(
    parameter int LIMIT = 1,
    parameter int W     = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic last,
    output logic pre
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            cnt <= '0;
        end else if (en && !last) begin
            cnt <= cnt + W'(1);
        end
    end

    assign last = (cnt == W'(LIMIT - 1));
    assign pre  = (LIMIT >= 2) && (cnt == W'(LIMIT - 2));

endmodule

// File: rtl/sseg_scroller.sv
// Scrolls a hex word across two active-low 7-seg digits, MS nibble first, then a blank gap.
// Latency: first window visible the cycle after the accepting edge; all outputs registered.
// Backpressure: ready_o only in IDLE (plus GAP when SSEG_SCROLL_LOOP_EN is defined, which repeats passes).
module sseg_scroller
    import step_pkg::*;
#(
    parameter int DIGITS = 8,
    parameter int DWELL  = 12_000_000,
    parameter int GAP    = 3_000_000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [4*DIGITS-1:0] word_i,
    input  logic                valid_i,
    output logic                ready_o,
    output logic                busy_o,
    output logic                done_o,
    output logic [1:0][3:0]     disp_num_n,
    output logic [1:0]          disp_en_n,
    output logic [1:0]          disp_dp_n
);

    localparam int CW = $clog2(((DWELL > GAP) ? DWELL : GAP) + 1);
    localparam int PW = (DIGITS > 2) ? $clog2(DIGITS - 1) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(DIGITS - 2);
`ifdef SSEG_SCROLL_LOOP_EN
    localparam bit GAP_READY = 1'b1;
`else
    localparam bit GAP_READY = 1'b0;
`endif

    state_t              state;
    logic [4*DIGITS-1:0] word_r;
    logic [PW-1:0]       p;
    logic                dwell_last, dwell_pre_unused;
    logic                gap_last, gap_pre;
    logic                take, restart, start;
    logic [4*DIGITS-1:0] start_word;

    // Inverted digit pair for window idx: left = nibble DIGITS-1-idx.
    function automatic logic [7:0] win_n(input logic [4*DIGITS-1:0] w, input logic [PW-1:0] idx);
        logic [4*DIGITS-1:0] s;
        s = w >> (4 * (DIGITS - 2 - int'(idx)));
        return ~s[7:0];
    endfunction

    assign take = valid_i && ready_o;
`ifdef SSEG_SCROLL_LOOP_EN
    assign restart = (state == step_pkg::GAP) && gap_last && !take;
`else
    assign restart = 1'b0;
`endif
    assign start      = take || restart;
    assign start_word = take ? word_i : word_r;

    dwell_timer #(.LIMIT(DWELL), .W(CW)) u_dwell (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   ((state != SHOW) || dwell_last),
        .en    (state == SHOW),
        .last  (dwell_last),
        .pre   (dwell_pre_unused)
    );

    dwell_timer #(.LIMIT(GAP), .W(CW)) u_gap (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   ((state != step_pkg::GAP) || gap_last),
        .en    (state == step_pkg::GAP),
        .last  (gap_last),
        .pre   (gap_pre)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            word_r     <= '0;
            p          <= '0;
            ready_o    <= 1'b1;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            disp_num_n <= {2{SSEG_BLANK_NUM_N}};
            disp_en_n  <= {2{SSEG_OFF_N}};
            disp_dp_n  <= {2{SSEG_OFF_N}};
        end else if (start) begin
            state      <= SHOW;
            word_r     <= start_word;
            p          <= '0;
            ready_o    <= 1'b0;
            busy_o     <= 1'b1;
            done_o     <= 1'b0;
            disp_num_n <= win_n(start_word, '0);
            disp_en_n  <= 2'b00;
            disp_dp_n  <= {1'b0, SSEG_OFF_N};
        end else begin
            case (state)
                SHOW: begin
                    if (dwell_last) begin
                        if (p != P_LAST) begin
                            p          <= p + PW'(1);
                            disp_num_n <= win_n(word_r, p + PW'(1));
                            disp_dp_n  <= {2{SSEG_OFF_N}};
                        end else begin
                            state      <= step_pkg::GAP;
                            ready_o    <= GAP_READY;
                            done_o     <= (GAP == 1);
                            disp_num_n <= {2{SSEG_BLANK_NUM_N}};
                            disp_en_n  <= {2{SSEG_OFF_N}};
                            disp_dp_n  <= {2{SSEG_OFF_N}};
                        end
                    end
                end
                step_pkg::GAP: begin
                    // done_o is registered, so it is raised one cycle ahead of gap_last.
                    if (gap_last) begin
                        state   <= IDLE;
                        ready_o <= 1'b1;
                        busy_o  <= 1'b0;
                        done_o  <= 1'b0;
                    end else begin
                        done_o  <= gap_pre;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sseg_scroller.sv
// Directed bench for sseg_scroller with DIGITS=4, DWELL=3, GAP=2: vector table plus corner sequences.
module tb_sseg_scroller;

    localparam int DIGITS = 4;
    localparam int DWELL  = 3;
    localparam int GAP    = 2;
`ifdef SSEG_SCROLL_LOOP_EN
    localparam bit LR = 1'b1;
`else
    localparam bit LR = 1'b0;
`endif

    logic            clk;
    logic            rst_n;
    logic [15:0]     word;
    logic            valid;
    logic            ready;
    logic            busy;
    logic            done;
    logic [1:0][3:0] num_n;
    logic [1:0]      en_n;
    logic [1:0]      dp_n;

    int n_checks = 0;
    int n_fail   = 0;

    sseg_scroller #(.DIGITS(DIGITS), .DWELL(DWELL), .GAP(GAP)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .word_i     (word),
        .valid_i    (valid),
        .ready_o    (ready),
        .busy_o     (busy),
        .done_o     (done),
        .disp_num_n (num_n),
        .disp_en_n  (en_n),
        .disp_dp_n  (dp_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    typedef struct {
        logic        rst_n;
        logic        valid;
        logic [15:0] word;
        logic [7:0]  num;
        logic [1:0]  dp;
        logic [1:0]  en;
        logic        rdy;
        logic        bsy;
        logic        dn;
    } vec_t;

    vec_t tbl [14];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [7:0] e_num, input logic [1:0] e_dp,
                             input logic [1:0] e_en, input logic e_rdy, input logic e_bsy,
                             input logic e_dn);
        check({tag, " num_n"}, 16'(num_n), 16'(e_num));
        check({tag, " dp_n"},  16'(dp_n),  16'(e_dp));
        check({tag, " en_n"},  16'(en_n),  16'(e_en));
        check({tag, " ready"}, 16'(ready), 16'(e_rdy));
        check({tag, " busy"},  16'(busy),  16'(e_bsy));
        check({tag, " done"},  16'(done),  16'(e_dn));
    endtask

    // Expected outputs for cycle k (1-based) of a pass; k=12 is the idle cycle after it.
    task automatic check_pass(input string tag, input logic [15:0] w, input int k);
        logic [15:0] s;
        logic [7:0]  e_num;
        int          p;
        p = (k - 1) / DWELL;
        if (k <= 3 * DWELL) begin
            s     = w >> (4 * (2 - p));
            e_num = ~s[7:0];
        end else begin
            e_num = 8'hFF;
        end
        check_all($sformatf("%s k%0d", tag, k), e_num,
                  (k <= DWELL) ? 2'b01 : 2'b11,
                  (k <= 3 * DWELL) ? 2'b00 : 2'b11,
                  (k == 12) || (LR && (k == 10 || k == 11)),
                  (k <= 11), (k == 11));
    endtask

    initial begin
        rst_n = 1'b0;
        valid = 1'b0;
        word  = 16'h0;

        //           rst v  word      num    dp     en     rdy bsy dn
        tbl[0]  = '{1'b0, 1'b0, 16'h0000, 8'hFF, 2'b11, 2'b11, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 16'h0000, 8'hFF, 2'b11, 2'b11, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 16'h0000, 8'hFF, 2'b11, 2'b11, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 16'h1A2B, 8'hE5, 2'b01, 2'b00, 1'b0, 1'b1, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 16'h0000, 8'hE5, 2'b01, 2'b00, 1'b0, 1'b1, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 16'hFFFF, 8'hE5, 2'b01, 2'b00, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 16'hFFFF, 8'h5D, 2'b11, 2'b00, 1'b0, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 16'h0000, 8'h5D, 2'b11, 2'b00, 1'b0, 1'b1, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 16'h0000, 8'h5D, 2'b11, 2'b00, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 16'h0000, 8'hD4, 2'b11, 2'b00, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 16'h0000, 8'hD4, 2'b11, 2'b00, 1'b0, 1'b1, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 16'h0000, 8'hD4, 2'b11, 2'b00, 1'b0, 1'b1, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 16'h0000, 8'hFF, 2'b11, 2'b11, LR,   1'b1, 1'b0};
        tbl[13] = '{1'b1, 1'b0, 16'h0000, 8'hFF, 2'b11, 2'b11, LR,   1'b1, 1'b1};

        for (int i = 0; i < 14; i++) begin
            rst_n = tbl[i].rst_n;
            valid = tbl[i].valid;
            word  = tbl[i].word;
            tick();
            check_all($sformatf("vec%0d", i), tbl[i].num, tbl[i].dp, tbl[i].en,
                      tbl[i].rdy, tbl[i].bsy, tbl[i].dn);
        end
        valid = 1'b0;
        word  = 16'h0;

`ifdef SSEG_SCROLL_LOOP_EN
        // Repeat with the held word, then replace it with a transfer during GAP.
        tick();
        check_pass("loop1A2B", 16'h1A2B, 1);
        for (int k = 2; k <= 10; k++) begin
            tick();
            check_pass("loop1A2B", 16'h1A2B, k);
        end
        valid = 1'b1;
        word  = 16'h00C3;
        tick();
        valid = 1'b0;
        word  = 16'h0;
        check_pass("loop00C3", 16'h00C3, 1);
        for (int k = 2; k <= 11; k++) begin
            tick();
            check_pass("loop00C3", 16'h00C3, k);
        end
        tick();
        check_pass("loop00C3 again", 16'h00C3, 1);
`else
        tick();
        check_all("idle after pass", 8'hFF, 2'b11, 2'b11, 1'b1, 1'b0, 1'b0);
        // valid_i held high: back-to-back passes with one idle cycle between.
        valid = 1'b1;
        word  = 16'h0001;
        for (int j = 1; j <= 24; j++) begin
            tick();
            check_pass("held0001", 16'h0001, ((j - 1) % 12) + 1);
        end
        valid = 1'b0;
        word  = 16'h0;
`endif

        // Reset mid-scroll aborts without a done pulse.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        valid = 1'b1;
        word  = 16'h1A2B;
        tick();
        valid = 1'b0;
        word  = 16'h0;
        check_pass("abort", 16'h1A2B, 1);
        for (int k = 2; k <= 5; k++) begin
            tick();
            check_pass("abort", 16'h1A2B, k);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_all("abort reset", 8'hFF, 2'b11, 2'b11, 1'b1, 1'b0, 1'b0);
        for (int j = 0; j < 12; j++) begin
            tick();
            check($sformatf("abort no done %0d", j), 16'(done), 16'h0);
            check($sformatf("abort blank %0d", j), 16'(en_n), 16'h3);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
